encoder_read_arbiter: RTL and testbench

ENCODER_READ_ARBITER -- requirements
Module: encoder_read_arbiter

---
 rtl/encoder_read_arbiter.sv | 155 +++++++++++++++
 tb/tb_encoder_read_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_read_arbiter.sv
// Round-robin arbiter sharing one I2C master among four wheel encoders.
// Each grant runs SETUP -> START -> WAIT (done/NACK/timeout) -> GAP, then re-arbitrates.
module encoder_read_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
  parameter logic [7:0]  GAP_CYCLES     = 8'd16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  ch_enable,
  input  logic        clear_err,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_error,
  input  logic [11:0] i2c_rd_data,
  output logic [1:0]  i2c_sel,
  output logic        i2c_start,
  output logic [47:0] current_angle,
  output logic [3:0]  rd_done,
  output logic [3:0]  timeout_err,
  output logic [3:0]  nack_err,
  output logic        busy,
  output logic [2:0]  o_dbg_state
);

  // Handshake: i2c_start is a one-cycle launch issued only while i2c_busy is low;
  // the master answers with a one-cycle i2c_done, i2c_error/i2c_rd_data valid alongside it.
  typedef enum logic [2:0] {
    ST_ARB   = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_last_ch;
  logic [1:0]  r_sel;
  logic [15:0] r_timer;
  logic [7:0]  r_gap;
  logic [47:0] r_angle;
  logic [3:0]  r_rd_done;
  logic [3:0]  r_timeout_err;
  logic [3:0]  r_nack_err;

  logic        w_grant_valid;
  logic [1:0]  w_grant_ch;
  logic [1:0]  w_scan_idx;
  logic [16:0] w_timer_inc;
  logic [8:0]  w_gap_inc;
  logic        w_timeout_hit;
  logic        w_gap_last;
  logic [3:0]  w_sel_onehot;
  logic        w_start;
  logic        w_latch;
  logic [3:0]  w_set_timeout;
  logic [3:0]  w_set_nack;

  // Scan farthest-first so the nearest enabled channel after r_last_ch wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_ch    = r_last_ch;
    w_scan_idx    = r_last_ch;
    for (int k = 4; k >= 1; k--) begin
      w_scan_idx = r_last_ch + 2'(k);
      if (ch_enable[w_scan_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_ch    = w_scan_idx;
      end
    end
  end

  assign w_timer_inc   = {1'b0, r_timer} + 17'd1;
  assign w_gap_inc     = {1'b0, r_gap} + 9'd1;
  assign w_timeout_hit = (w_timer_inc >= {1'b0, TIMEOUT_CYCLES});
  assign w_gap_last    = (w_gap_inc >= {1'b0, GAP_CYCLES});
  assign w_sel_onehot  = 4'b0001 << r_sel;

  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_latch       = 1'b0;
    w_set_timeout = 4'b0000;
    w_set_nack    = 4'b0000;
    case (r_state)
      ST_ARB:   if (w_grant_valid) w_state_next = ST_SETUP;
      ST_SETUP: w_state_next = ST_START;
      ST_START: begin
        if (!i2c_busy) begin
          w_start      = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done arriving on the final timer cycle takes precedence over the timeout.
        if (i2c_done) begin
          if (i2c_error) w_set_nack = w_sel_onehot;
          else           w_latch    = 1'b1;
          w_state_next = ST_GAP;
        end else if (w_timeout_hit) begin
          w_set_timeout = w_sel_onehot;
          w_state_next  = ST_GAP;
        end
      end
      ST_GAP:   if (w_gap_last) w_state_next = ST_ARB;
      default:  w_state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_ARB;
      r_last_ch     <= 2'd3;
      r_sel         <= 2'd0;
      r_timer       <= 16'd0;
      r_gap         <= 8'd0;
      r_angle       <= 48'd0;
      r_rd_done     <= 4'b0000;
      r_timeout_err <= 4'b0000;
      r_nack_err    <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_ARB && w_grant_valid) begin
        r_sel     <= w_grant_ch;
        r_last_ch <= w_grant_ch;
      end
      if (w_start) begin
        r_timer <= 16'd0;
      end else if (r_state == ST_WAIT && r_timer != 16'hFFFF) begin
        r_timer <= r_timer + 16'd1;
      end
      if (r_state != ST_GAP) begin
        r_gap <= 8'd0;
      end else if (r_gap != 8'hFF) begin
        r_gap <= r_gap + 8'd1;
      end
      for (int n = 0; n < 4; n++) begin
        if (w_latch && r_sel == 2'(n)) r_angle[12*n +: 12] <= i2c_rd_data;
      end
      r_rd_done     <= w_latch ? w_sel_onehot : 4'b0000;
      r_timeout_err <= (r_timeout_err & ~{4{clear_err}}) | w_set_timeout;
      r_nack_err    <= (r_nack_err & ~{4{clear_err}}) | w_set_nack;
    end
  end

  assign i2c_sel       = r_sel;
  assign i2c_start     = w_start;
  assign current_angle = r_angle;
  assign rd_done       = r_rd_done;
  assign timeout_err   = r_timeout_err;
  assign nack_err      = r_nack_err;
  assign busy          = (r_state != ST_ARB);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_encoder_read_arbiter.sv
// Bench for encoder_read_arbiter: a responder stands in for the I2C master and a
// transaction-phase model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_encoder_read_arbiter;

  localparam logic [15:0] T_CYC = 16'd64;
  localparam logic [7:0]  G_CYC = 8'd4;
  localparam int T_INT = 64;
  localparam int G_INT = 4;

  localparam int PH_IDLE   = 0;
  localparam int PH_SETUP  = 1;
  localparam int PH_LAUNCH = 2;
  localparam int PH_WAIT   = 3;
  localparam int PH_COOL   = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  ch_enable = 4'b0;
  logic        clear_main = 1'b0;
  logic        clear_resp = 1'b0;
  logic        clear_err;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_error = 1'b0;
  logic [11:0] i2c_rd_data = 12'h0;
  logic [1:0]  i2c_sel;
  logic        i2c_start;
  logic [47:0] current_angle;
  logic [3:0]  rd_done;
  logic [3:0]  timeout_err;
  logic [3:0]  nack_err;
  logic        busy;
  logic [2:0]  dbg_state;

  assign clear_err = clear_main | clear_resp;

  encoder_read_arbiter #(.TIMEOUT_CYCLES(T_CYC), .GAP_CYCLES(G_CYC)) dut (
    .clock(clock), .reset_n(reset_n), .ch_enable(ch_enable), .clear_err(clear_err),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_error(i2c_error),
    .i2c_rd_data(i2c_rd_data), .i2c_sel(i2c_sel), .i2c_start(i2c_start),
    .current_angle(current_angle), .rd_done(rd_done), .timeout_err(timeout_err),
    .nack_err(nack_err), .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s at cycle %0d: wait bound expired", name, cyc);
  endtask

  // ---------------- responder knobs ----------------
  logic       force_busy = 1'b0;
  int         busy_pct = 0, err_pct = 0, drop_pct = 0;
  logic [3:0] err_mask = 4'b0, drop_mask = 4'b0;
  int         lat_min = 20, lat_max = 20;
  logic       data_fixed = 1'b1;
  logic       stray_en = 1'b0;
  logic       clr_on_nack = 1'b0;

  // Logs of what the DUT actually did (used by directed checks against literals)
  int start_sel_q[$];
  int start_cyc_q[$];
  int rd_log_q[$];
  int terr_rise_cyc = -1;
  logic [3:0] prev_terr = 4'b0;
  int dut_start_cyc = -1;
  int dut_start_sel = 0;

  // ---------------- reference model ----------------
  int         m_phase = PH_IDLE;
  int         m_last = 3;
  int         m_sel = 0;
  int         wait_left = 0;
  int         cool_left = 0;
  int         m_ends = 0;
  logic [11:0] m_angle [4];
  logic [3:0] m_rd = 4'b0, m_terr = 4'b0, m_nerr = 4'b0;
  logic [3:0] set_t, set_n, rd_next;
  logic [47:0] exp_angle;

  function automatic int rr_pick(input logic [3:0] en, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (en[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Compare process: checks this cycle's outputs, then steps the model across the next edge.
  always @(negedge clock) begin
    int pick;
    cyc++;
    if (!reset_n) begin
      m_phase = PH_IDLE; m_last = 3; m_sel = 0; wait_left = 0; cool_left = 0;
      m_rd = 4'b0; m_terr = 4'b0; m_nerr = 4'b0;
      for (int n = 0; n < 4; n++) m_angle[n] = 12'h0;
    end
    for (int n = 0; n < 4; n++) exp_angle[12*n +: 12] = m_angle[n];
    chk("busy", busy, m_phase != PH_IDLE);
    chk("i2c_start", i2c_start, (m_phase == PH_LAUNCH) && !i2c_busy);
    chk("i2c_sel", i2c_sel, m_sel);
    chk("rd_done", rd_done, m_rd);
    chk("current_angle", current_angle, exp_angle);
    chk("timeout_err", timeout_err, m_terr);
    chk("nack_err", nack_err, m_nerr);

    if (i2c_start === 1'b1) begin
      start_sel_q.push_back(int'(i2c_sel));
      start_cyc_q.push_back(cyc);
      dut_start_cyc = cyc;
      dut_start_sel = int'(i2c_sel);
    end
    for (int n = 0; n < 4; n++) if (rd_done[n] === 1'b1) rd_log_q.push_back(n);
    if (timeout_err != 4'b0 && prev_terr == 4'b0 && terr_rise_cyc < 0) terr_rise_cyc = cyc;
    prev_terr = timeout_err;

    if (reset_n) begin
      set_t = 4'b0; set_n = 4'b0; rd_next = 4'b0;
      case (m_phase)
        PH_IDLE: begin
          pick = rr_pick(ch_enable, m_last);
          if (pick >= 0) begin m_sel = pick; m_last = pick; m_phase = PH_SETUP; end
        end
        PH_SETUP: m_phase = PH_LAUNCH;
        PH_LAUNCH: if (!i2c_busy) begin m_phase = PH_WAIT; wait_left = T_INT; end
        PH_WAIT: begin
          if (i2c_done) begin
            if (i2c_error) set_n[m_sel] = 1'b1;
            else begin m_angle[m_sel] = i2c_rd_data; rd_next[m_sel] = 1'b1; end
            m_phase = PH_COOL; cool_left = (G_INT == 0) ? 1 : G_INT; m_ends++;
          end else if (wait_left <= 1) begin
            set_t[m_sel] = 1'b1;
            m_phase = PH_COOL; cool_left = (G_INT == 0) ? 1 : G_INT; m_ends++;
          end else begin
            wait_left--;
          end
        end
        default: begin
          if (cool_left <= 1) m_phase = PH_IDLE;
          else cool_left--;
        end
      endcase
      m_rd   = rd_next;
      m_terr = (clear_err ? 4'b0 : m_terr) | set_t;
      m_nerr = (clear_err ? 4'b0 : m_nerr) | set_n;
    end
  end

  // ---------------- I2C master stand-in ----------------
  int   handled_cyc = -1;
  logic pend = 1'b0;
  int   pend_ch = 0, pend_cnt = 0;
  logic pend_err = 1'b0;

  always @(posedge clock) begin
    #2;
    i2c_done = 1'b0; i2c_error = 1'b0; clear_resp = 1'b0;
    if (!reset_n) begin
      pend = 1'b0;
      handled_cyc = dut_start_cyc;
    end else if (dut_start_cyc != handled_cyc) begin
      handled_cyc = dut_start_cyc;
      pend_ch  = dut_start_sel;
      pend     = !(drop_mask[pend_ch] || ($urandom_range(0, 99) < drop_pct));
      pend_err = err_mask[pend_ch] || ($urandom_range(0, 99) < err_pct);
      pend_cnt = $urandom_range(lat_min, lat_max);
    end else if (pend) begin
      if (pend_cnt <= 1) begin
        i2c_done = 1'b1;
        i2c_error = pend_err;
        i2c_rd_data = data_fixed ? 12'(12'h100 + pend_ch) : 12'($urandom);
        if (pend_err && clr_on_nack) clear_resp = 1'b1;
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end else if (stray_en && $urandom_range(0, 99) < 4) begin
      i2c_done = 1'b1;
      i2c_error = 1'($urandom_range(0, 1));
      i2c_rd_data = 12'($urandom);
    end
    i2c_busy = force_busy || ($urandom_range(0, 99) < busy_pct);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    start_sel_q.delete(); start_cyc_q.delete(); rd_log_q.delete();
    terr_rise_cyc = -1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    step(1);
    reset_n = 1'b0; ch_enable = 4'b0; clear_main = 1'b0;
    step(3);
    clear_logs();
    reset_n = 1'b1;
  endtask

  task automatic wait_rd(input int n, input int budget, input string name);
    int k = 0;
    while (rd_log_q.size() < n && k < budget) begin step(1); k++; end
    if (rd_log_q.size() < n) bound_fail(name);
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k = 0;
    while (start_sel_q.size() < n && k < budget) begin step(1); k++; end
    if (start_sel_q.size() < n) bound_fail(name);
  endtask

  task automatic wait_ends(input int target, input int budget, input string name);
    int k = 0;
    while (m_ends < target && k < budget) begin step(1); k++; end
    if (m_ends < target) bound_fail(name);
  endtask

  task automatic pulse_clear();
    clear_main = 1'b1;
    step(1);
    clear_main = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int order[5];
    int rel, base, cnt1;
    order = '{0, 1, 2, 3, 0};

    step(3);
    chk("reset_busy", busy, 1'b0);
    chk("reset_start", i2c_start, 1'b0);
    chk("reset_sel", i2c_sel, 2'd0);
    chk("reset_rd_done", rd_done, 4'b0);
    chk("reset_angle", current_angle, 48'h0);
    chk("reset_errs", {timeout_err, nack_err}, 8'h00);
    reset_n = 1'b1;

    // All four channels, fixed 0x100+n data
    clear_logs();
    ch_enable = 4'hF;
    wait_rd(5, 600, "rr_wait");
    ch_enable = 4'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < start_sel_q.size()) chk("rr_sel_order", start_sel_q[i], order[i]);
      if (i < rd_log_q.size())    chk("rr_rd_order", rd_log_q[i], order[i]);
    end
    chk("rr_angle", current_angle, 48'h103102101100);
    step(20);

    // Sole enabled channel re-served every round
    do_reset();
    ch_enable = 4'b0100;
    wait_rd(3, 400, "solo_wait");
    ch_enable = 4'b0;
    foreach (rd_log_q[i]) chk("solo_rd_ch", rd_log_q[i], 2);
    foreach (start_sel_q[i]) chk("solo_sel", start_sel_q[i], 2);
    chk("solo_angle", current_angle, 48'h000102000000);
    step(20);

    // Master busy for 50 cycles while the arbiter wants to start
    force_busy = 1'b1;
    do_reset();
    ch_enable = 4'b0001;
    step(50);
    chk("busy_hold_no_start", start_sel_q.size(), 0);
    rel = cyc + 1;
    force_busy = 1'b0;
    @(negedge clock); #1;
    chk("busy_release_start", start_sel_q.size(), 1);
    if (start_cyc_q.size() > 0) chk("busy_release_cycle", start_cyc_q[0], rel);
    step(1);
    ch_enable = 4'b0;
    wait_rd(1, 200, "busy_rd_wait");
    step(10);

    // Channel 1 never answered: timeout after exactly T cycles, then ch2 is served
    do_reset();
    drop_mask = 4'b0010;
    ch_enable = 4'b0110;
    wait_starts(2, 600, "to_wait");
    ch_enable = 4'b0;
    drop_mask = 4'b0;
    if (start_sel_q.size() >= 2) begin
      chk("to_first_sel", start_sel_q[0], 1);
      chk("to_next_sel", start_sel_q[1], 2);
    end
    chk("to_flag", timeout_err, 4'b0010);
    // Start is sampled on the edge closing its cycle; the flag shows one cycle after its edge.
    chk("to_latency", terr_rise_cyc - start_cyc_q[0], T_INT + 1);
    wait_rd(1, 200, "to_ch2_rd");
    cnt1 = 0;
    foreach (rd_log_q[i]) if (rd_log_q[i] == 1) cnt1++;
    chk("to_no_rd1", cnt1, 0);
    step(10);
    pulse_clear();
    chk("to_cleared", timeout_err, 4'b0);

    // Done on the last timer cycle wins over the timeout
    clear_logs();
    lat_min = T_INT - 1; lat_max = T_INT - 1;
    ch_enable = 4'b0001;
    wait_rd(1, 300, "edge_done_wait");
    ch_enable = 4'b0;
    chk("edge_done_no_to", timeout_err, 4'b0);
    if (rd_log_q.size() > 0) chk("edge_done_rd", rd_log_q[0], 0);
    step(10);

    // Done one cycle late: timeout, late done ignored
    clear_logs();
    lat_min = T_INT; lat_max = T_INT;
    ch_enable = 4'b0001;
    wait_starts(1, 100, "late_start");
    ch_enable = 4'b0;
    step(T_INT + 20);
    chk("late_to_flag", timeout_err, 4'b0001);
    chk("late_no_rd", rd_log_q.size(), 0);
    pulse_clear();
    lat_min = 20; lat_max = 20;

    // NACK on ch3, then clear coincident with a fresh NACK on ch0
    do_reset();
    err_mask = 4'b1001;
    ch_enable = 4'b1001;
    base = m_ends;
    wait_ends(base + 2, 400, "nack_wait");
    chk("nack_flags", nack_err, 4'b1001);
    chk("nack_angle3", current_angle[47:36], 12'h000);
    chk("nack_no_rd", rd_log_q.size(), 0);
    clr_on_nack = 1'b1;
    wait_ends(base + 3, 400, "nack_clear_wait");
    ch_enable = 4'b0;
    clr_on_nack = 1'b0;
    chk("nack_set_wins", nack_err, 4'b0001);
    if (start_sel_q.size() >= 3) chk("nack_third_sel", start_sel_q[2], 0);
    err_mask = 4'b0;
    step(20);

    // Reset in the middle of the ch2 wait
    do_reset();
    lat_min = 40; lat_max = 40;
    ch_enable = 4'hF;
    wait_starts(3, 400, "midrst_wait");
    step(5);
    reset_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_angle", current_angle, 48'h0);
    chk("midrst_sel", i2c_sel, 2'd0);
    chk("midrst_start", i2c_start, 1'b0);
    chk("midrst_rd", rd_done, 4'b0);
    step(2);
    clear_logs();
    reset_n = 1'b1;
    wait_starts(1, 100, "midrst_restart");
    if (start_sel_q.size() > 0) chk("midrst_first_ch0", start_sel_q[0], 0);
    ch_enable = 4'b0;
    step(60);

    // Randomized traffic
    data_fixed = 1'b0; busy_pct = 30; err_pct = 20; drop_pct = 10;
    lat_min = 1; lat_max = T_INT + 2; stray_en = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      step(1);
      if ($urandom_range(0, 99) < 3) ch_enable = 4'($urandom);
      clear_main = ($urandom_range(0, 99) < 2);
      reset_n = !($urandom_range(0, 1999) == 0);
    end
    reset_n = 1'b1; clear_main = 1'b0; ch_enable = 4'b0; stray_en = 1'b0;
    step(150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
